store_seq: RTL and testbench
============================

STORE_SEQ -- requirements
Module: store_seq

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning the number of wait cycles between presenting a read address and valid mem_rdata; legal range 1..4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a store; sampled only in IDLE.
REQ-005 SHALL have port store_type, input, 2, the store kind: 00 sw, 01 sh, 10 sb, 11 illegal.
REQ-006 SHALL have port addr, input, 32, the byte address of the store.
REQ-007 SHALL have port mem_addr, output, 32, the memory address, registered.
REQ-008 SHALL have port mem_wr, output, 1, the memory write strobe.
REQ-009 SHALL have port mdr_load, output, 1, which loads the memory data register from the memory read word.
REQ-010 SHALL have port StoreSize_Ctrl, output, 2, which selects the store-size merge (00 word, 01 half, 10 byte).
REQ-011 SHALL have port busy, output, 1, high while a store is in progress.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse on successful completion.
REQ-013 SHALL have port err, output, 1, a one-cycle pulse on a rejected request.

Function
REQ-014 SHALL implement the states IDLE, READ, WAIT, CAPTURE, WRITE and FIN.
REQ-015 In IDLE with start=1, SHALL latch store_type and addr into internal registers, load mem_addr from addr, and then perform the first legal transition below.
REQ-016 If store_type=11, or sw with addr[1:0]!=00, or sh with addr[0]=1, SHALL pulse err for the next cycle, stay in IDLE, and assert no mem_wr or mdr_load.
REQ-017 A legal sw SHALL go IDLE->WRITE and skip the read-modify-write.
REQ-018 A legal sh or sb SHALL go IDLE->READ.
REQ-019 In READ, mem_wr SHALL be 0 and the next state SHALL be WAIT, with a wait counter loaded with MEM_LAT-1.
REQ-020 In WAIT, the block SHALL decrement the counter and go to CAPTURE when it reaches 0, so that WAIT lasts exactly MEM_LAT cycles.
REQ-021 In CAPTURE, mdr_load SHALL be 1 for exactly one cycle, followed by WRITE.
REQ-022 In WRITE, mem_wr SHALL be 1 for exactly one cycle, followed by FIN.
REQ-023 In FIN, done SHALL be 1 for exactly one cycle, followed by IDLE.
REQ-024 StoreSize_Ctrl SHALL equal the latched store_type in CAPTURE and WRITE, and 00 in all other states.
REQ-025 mem_addr SHALL hold the latched address unchanged from READ through FIN.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start asserted while busy=1 SHALL be ignored (no queuing), and the latched fields SHALL not change.
REQ-028 Changes on store_type or addr after the start cycle SHALL have no effect on the operation in progress.
REQ-029 The cycle count from the start edge to done SHALL be 2 for sw and MEM_LAT+4 for sh and sb.
REQ-030 mem_wr, mdr_load, done and err SHALL never be high in the same cycle as one another.
REQ-031 A start arriving in the same cycle as done is high SHALL be ignored, because the state is FIN; a new start is accepted from IDLE onward.

Reset
REQ-032 When reset_n=0, SHALL immediately force state IDLE with mem_addr=0, mem_wr=0, mdr_load=0, StoreSize_Ctrl=00, busy=0, done=0 and err=0, and clear the counter and latched fields.
REQ-033 Reset mid-operation, including during WRITE, SHALL abort the operation with no further mem_wr; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-034 A bench SHALL check: sw, addr=0x100, start pulse -> mem_wr=1 one cycle later with StoreSize_Ctrl=00 and mem_addr=0x100, done one cycle after that, mdr_load never asserted.
REQ-035 A bench SHALL check: sb, addr=0x203, MEM_LAT=1 -> READ, WAIT(1), mdr_load, mem_wr with StoreSize_Ctrl=10, done 5 cycles after start, mem_addr=0x203 throughout.
REQ-036 A bench SHALL check: sh, MEM_LAT=3, addr=0x40 -> done 7 cycles after start, with StoreSize_Ctrl=01 during CAPTURE and WRITE.
REQ-037 A bench SHALL check: sh at addr=0x41, then sw at addr=0x102, then type 11 -> each produces a one-cycle err, with busy, mem_wr and mdr_load staying 0.
REQ-038 A bench SHALL check: a second start pulse in WAIT with a changed type and address -> the first operation completes unchanged and the second start is not executed.
REQ-039 A bench SHALL check: reset_n low during WRITE -> all outputs 0 immediately, no done pulse, and a fresh sw after release completes normally.

Source files
------------

// File: rtl/store_seq_if.sv
// Request/memory bus of the store sequencer.
// The requester drives start/store_type/addr; the sequencer drives the
// memory-side strobes and status flags.
interface store_seq_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic        mdr_load;
  logic [1:0]  StoreSize_Ctrl;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, store_type, addr,
    input  mem_addr, mem_wr, mdr_load, StoreSize_Ctrl, busy, done, err
  );

  modport slave (
    input  start, store_type, addr,
    output mem_addr, mem_wr, mdr_load, StoreSize_Ctrl, busy, done, err
  );
endinterface

// File: rtl/store_seq.sv
// Store sequencer: issues a word store directly, or a read-modify-write
// (read, wait MEM_LAT cycles, capture into MDR, write) for half/byte stores.
// Misaligned or illegal requests are rejected with a one-cycle err pulse.
// All outputs are registers decoded from the next state, so each output
// lines up with the state it belongs to.
module store_seq #(
  parameter int MEM_LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  store_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    WRITE   = 3'd4,
    FIN     = 3'd5
  } state_t;

  localparam logic [1:0] ST_SW   = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_ILL  = 2'b11;
  localparam logic [1:0] LAT_M1  = 2'(MEM_LAT - 1);

  state_t      state_r, state_s;
  logic [1:0]  type_r, type_s;
  logic [31:0] addr_r, addr_s;
  logic [1:0]  cnt_r, cnt_s;
  logic        err_s;

  logic        mem_wr_r;
  logic        mdr_load_r;
  logic        done_r;
  logic        err_r;
  logic        busy_r;
  logic [1:0]  size_r;

  // A request is rejected for the reserved type or a misaligned address.
  function automatic logic is_illegal(input logic [1:0] t, input logic [1:0] a_lo);
    logic ill;
    ill = 1'b0;
    if (t == ST_ILL) begin
      ill = 1'b1;
    end else if (t == ST_SW) begin
      ill = (a_lo != 2'b00);
    end else if (t == ST_SH) begin
      ill = a_lo[0];
    end else begin
      ill = 1'b0;
    end
    return ill;
  endfunction

  // Next-state, latched-field and wait-counter logic.
  always_comb begin
    state_s = state_r;
    type_s  = type_r;
    addr_s  = addr_r;
    cnt_s   = cnt_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          type_s = bus.store_type;
          addr_s = bus.addr;
          if (is_illegal(bus.store_type, bus.addr[1:0])) begin
            err_s   = 1'b1;
            state_s = IDLE;
          end else if (bus.store_type == ST_SW) begin
            state_s = WRITE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        state_s = WAIT;
        cnt_s   = LAT_M1;
      end
      WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = CAPTURE;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      CAPTURE: state_s = WRITE;
      WRITE:   state_s = FIN;
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched request and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      type_r  <= 2'b00;
      addr_r  <= 32'h0000_0000;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      type_r  <= type_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output registers decoded from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wr_r   <= 1'b0;
      mdr_load_r <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      size_r     <= 2'b00;
    end else begin
      mem_wr_r   <= (state_s == WRITE);
      mdr_load_r <= (state_s == CAPTURE);
      done_r     <= (state_s == FIN);
      err_r      <= err_s;
      busy_r     <= (state_s != IDLE);
      size_r     <= ((state_s == CAPTURE) || (state_s == WRITE)) ? type_s : 2'b00;
    end
  end

  // The latched address register doubles as the registered memory address.
  assign bus.mem_addr       = addr_r;
  assign bus.mem_wr         = mem_wr_r;
  assign bus.mdr_load       = mdr_load_r;
  assign bus.done           = done_r;
  assign bus.err            = err_r;
  assign bus.busy           = busy_r;
  assign bus.StoreSize_Ctrl = size_r;

endmodule

// File: tb/tb_store_seq.sv
// Directed bench for store_seq: two instances (MEM_LAT=1 and MEM_LAT=3).
// Each operation pushes its expected timing into a scoreboard queue; the
// observation window then pops it and compares against what the DUT did.
module tb_store_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  store_seq_if bus1 ();
  store_seq_if bus3 ();

  store_seq #(.MEM_LAT(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  store_seq #(.MEM_LAT(3)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  typedef struct {
    bit          err;
    int          wr_cyc;
    int          cap_cyc;
    int          done_cyc;
    logic [1:0]  size;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  logic [31:0] b_mem_addr;
  logic        b_wr, b_ld, b_done, b_err, b_busy;
  logic [1:0]  b_size;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      b_mem_addr = bus1.mem_addr; b_wr = bus1.mem_wr; b_ld = bus1.mdr_load;
      b_done = bus1.done; b_err = bus1.err; b_busy = bus1.busy; b_size = bus1.StoreSize_Ctrl;
    end else begin
      b_mem_addr = bus3.mem_addr; b_wr = bus3.mem_wr; b_ld = bus3.mdr_load;
      b_done = bus3.done; b_err = bus3.err; b_busy = bus3.busy; b_size = bus3.StoreSize_Ctrl;
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [1:0] t, input logic [31:0] a);
    if (sel == 0) begin
      bus1.start = st; bus1.store_type = t; bus1.addr = a;
    end else begin
      bus3.start = st; bus3.store_type = t; bus3.addr = a;
    end
  endtask

  // Expected behaviour in cycles counted from the cycle start is high.
  function automatic exp_t model(input logic [1:0] t, input logic [31:0] a, input int ml);
    exp_t e;
    e.addr = a; e.size = t; e.err = 1'b0;
    e.wr_cyc = -1; e.cap_cyc = -1; e.done_cyc = -1;
    if (t == 2'b11 || (t == 2'b00 && a[1:0] != 2'b00) || (t == 2'b01 && a[0])) begin
      e.err = 1'b1;
    end else if (t == 2'b00) begin
      e.wr_cyc = 1; e.done_cyc = 2;
    end else begin
      e.cap_cyc = ml + 2; e.wr_cyc = ml + 3; e.done_cyc = ml + 4;
    end
    return e;
  endfunction

  task automatic run_op(input string name, input int sel, input int ml,
                        input logic [1:0] t, input logic [31:0] a,
                        input int inj_cyc, input logic [1:0] inj_t, input logic [31:0] inj_a);
    exp_t e, cur;
    int wr_cyc, cap_cyc, done_cyc, err_cyc;
    int n_wr, n_ld, n_done, n_err, n_strb;
    int addr_bad, overlap, busy_bad, size_bad;
    logic [1:0] size_wr, size_cap;
    logic exp_busy;
    wr_cyc = -1; cap_cyc = -1; done_cyc = -1; err_cyc = -1;
    n_wr = 0; n_ld = 0; n_done = 0; n_err = 0;
    addr_bad = 0; overlap = 0; busy_bad = 0; size_bad = 0;
    size_wr = 2'b00; size_cap = 2'b00;
    cur = model(t, a, ml);
    sb_q.push_back(cur);
    @(negedge clk);
    drive(sel, 1'b1, t, a);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, ~t, ~a);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      sample(sel);
      if (b_wr)   begin n_wr++;   if (wr_cyc < 0)   begin wr_cyc = k;   size_wr = b_size;  end end
      if (b_ld)   begin n_ld++;   if (cap_cyc < 0)  begin cap_cyc = k;  size_cap = b_size; end end
      if (b_done) begin n_done++; if (done_cyc < 0) done_cyc = k; end
      if (b_err)  begin n_err++;  if (err_cyc < 0)  err_cyc = k;  end
      n_strb = int'(b_wr) + int'(b_ld) + int'(b_done) + int'(b_err);
      if (n_strb > 1) overlap++;
      if (b_busy && b_mem_addr !== a) addr_bad++;
      if (!b_wr && !b_ld && b_size !== 2'b00) size_bad++;
      exp_busy = (k <= cur.done_cyc);
      if (b_busy !== exp_busy) busy_bad++;
      if (k == inj_cyc) begin
        drive(sel, 1'b1, inj_t, inj_a);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 2'b00, 32'h0);
      end
    end
    e = sb_q.pop_front();
    check({name, ".err_cyc"},  err_cyc,  e.err ? 1 : -1);
    check({name, ".n_err"},    n_err,    e.err ? 1 : 0);
    check({name, ".wr_cyc"},   wr_cyc,   e.wr_cyc);
    check({name, ".n_wr"},     n_wr,     (e.wr_cyc > 0) ? 1 : 0);
    check({name, ".cap_cyc"},  cap_cyc,  e.cap_cyc);
    check({name, ".n_ld"},     n_ld,     (e.cap_cyc > 0) ? 1 : 0);
    check({name, ".done_cyc"}, done_cyc, e.done_cyc);
    check({name, ".n_done"},   n_done,   (e.done_cyc > 0) ? 1 : 0);
    check({name, ".size_wr"},  {30'd0, size_wr},  (e.wr_cyc > 0) ? {30'd0, e.size} : 32'd0);
    check({name, ".size_cap"}, {30'd0, size_cap}, (e.cap_cyc > 0) ? {30'd0, e.size} : 32'd0);
    check({name, ".addr_bad"}, addr_bad, 0);
    check({name, ".overlap"},  overlap,  0);
    check({name, ".busy_bad"}, busy_bad, 0);
    check({name, ".size_bad"}, size_bad, 0);
  endtask

  initial begin
    int found, n_after;
    reset_n = 1'b0;
    drive(0, 1'b0, 2'b00, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    sample(0);
    check("reset1", {b_wr, b_ld, b_done, b_err, b_busy, b_size, b_mem_addr}, 32'h0);
    sample(1);
    check("reset3", {b_wr, b_ld, b_done, b_err, b_busy, b_size, b_mem_addr}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("sw100",  0, 1, 2'b00, 32'h0000_0100, 0, 2'b00, 32'h0);
    run_op("sb203",  0, 1, 2'b10, 32'h0000_0203, 0, 2'b00, 32'h0);
    run_op("sh40",   1, 3, 2'b01, 32'h0000_0040, 0, 2'b00, 32'h0);
    run_op("sh41",   0, 1, 2'b01, 32'h0000_0041, 0, 2'b00, 32'h0);
    run_op("sw102",  0, 1, 2'b00, 32'h0000_0102, 0, 2'b00, 32'h0);
    run_op("type11", 0, 1, 2'b11, 32'h0000_0000, 0, 2'b00, 32'h0);
    run_op("sb_inj", 1, 3, 2'b10, 32'h0000_0055, 3, 2'b00, 32'h0000_0800);
    run_op("sw_fin", 0, 1, 2'b00, 32'h0000_0104, 2, 2'b00, 32'h0000_0200);
    run_op("sh42",   0, 1, 2'b01, 32'h0000_0042, 0, 2'b00, 32'h0);

    // Reset asserted while the write strobe is high.
    found = 0;
    @(negedge clk);
    drive(0, 1'b1, 2'b10, 32'h0000_0301);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 2'b00, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sample(0);
      if (b_wr) begin
        found = 1;
        break;
      end
    end
    check("rst_saw_write", found, 1);
    reset_n = 1'b0;
    #1;
    sample(0);
    check("rst_in_write", {b_wr, b_ld, b_done, b_err, b_busy, b_size, b_mem_addr}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    n_after = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sample(0);
      n_after += int'(b_wr) + int'(b_done) + int'(b_busy);
    end
    check("rst_quiet", n_after, 0);
    run_op("sw_post", 0, 1, 2'b00, 32'h0000_0108, 0, 2'b00, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
